// File: rtl/regfile_write_arbiter.sv
// Round-robin write-port arbiter (A=ALU, B=load) with a pending-destination scoreboard and read-hazard stall.
// One-cycle write latency; a requester is held off (ready low) while the other owns the port or reset is high.
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int NREGS  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              rs_check,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              stall,
  output logic              wr_enable,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [NREGS-1:0]  pending
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wrReq_t;

  logic       prioB;
  logic       grantA;
  logic       grantB;
  logic       xfer;
  wrReq_t     xferReq;
  logic [NREGS-1:0] pendingNext;

  always_comb begin
    grantA = 1'b0;
    grantB = 1'b0;
    if (!rst) begin
      if (a_valid && b_valid) begin
        grantA = !prioB;
        grantB = prioB;
      end else begin
        grantA = a_valid;
        grantB = b_valid;
      end
    end
  end

  assign a_ready = grantA;
  assign b_ready = grantB;
  assign xfer    = grantA | grantB;

  always_comb begin
    xferReq = grantB ? wrReq_t'{addr: b_addr, data: b_data}
                     : wrReq_t'{addr: a_addr, data: a_data};
  end

  // Set after clear so a same-cycle reserve keeps the register pending.
  always_comb begin
    pendingNext = pending;
    if (xfer) begin
      pendingNext[xferReq.addr] = 1'b0;
    end
    if (rsv_valid) begin
      pendingNext[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prioB     <= 1'b0;
      wr_enable <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      pending   <= '0;
    end else begin
      wr_enable <= xfer;
      if (xfer) begin
        wr_addr <= xferReq.addr;
        wr_data <= xferReq.data;
      end
      if (grantA) begin
        prioB <= 1'b1;
      end else if (grantB) begin
        prioB <= 1'b0;
      end
      pending <= pendingNext;
    end
  end

  // The write still sitting on the port counts as in flight.
  function automatic logic isHit(input logic [ADDR_W-1:0] r);
    return pending[r] | (wr_enable & (wr_addr == r));
  endfunction

  assign stall = rs_check & (isHit(rs1_addr) | isHit(rs2_addr));

endmodule
